// File: rtl/m_sorted_serializer.sv
// Streams one M-wide sorted vector per handshake as M single elements, ascending or descending,
// and flags any accepted vector that is not non-decreasing.
module m_sorted_serializer #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N-1:0]         in_data [M-1:0],
    input  logic                 in_valid,
    input  logic                 in_dir,
    output logic                 in_ready,
    output logic [N-1:0]         out_data,
    output logic [$clog2(M)-1:0] out_idx,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 order_err,
    output logic [7:0]           err_cnt
);

    localparam int unsigned IW = $clog2(M);
    localparam logic [IW-1:0] LastCnt = IW'(M - 1);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   vec_q [M-1:0];
    logic           dir_q;
    logic [IW-1:0]  cnt_q, cnt_d;
    logic           order_err_q, order_err_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic           drain, load, xfer, unsorted;
    logic [IW-1:0]  idx;

    always_comb begin
        unsorted = 1'b0;
        for (int i = 0; i < int'(M) - 1; i++) begin
            if (in_data[i] > in_data[i+1]) unsorted = 1'b1;
        end
    end

    always_comb begin
        drain     = (state_q == StDrain);
        out_valid = drain;
        out_last  = drain && (cnt_q == LastCnt);
        idx       = dir_q ? (LastCnt - cnt_q) : cnt_q;
        out_idx   = drain ? idx : '0;
        out_data  = drain ? vec_q[idx] : '0;
        // Held low through reset; accepting on the last transfer gives bubble-free streaming.
        in_ready  = !Reset && (!drain || (out_ready && out_last));
        xfer      = out_valid && out_ready;
        load      = in_valid && in_ready;

        state_d     = state_q;
        cnt_d       = cnt_q;
        order_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (xfer) begin
            if (out_last) state_d = StIdle;
            else          cnt_d   = cnt_q + 1'b1;
        end
        if (load) begin
            state_d = StDrain;
            cnt_d   = '0;
            if (unsorted) begin
                order_err_d = 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            order_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
            for (int i = 0; i < int'(M); i++) vec_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            order_err_q <= order_err_d;
            err_cnt_q   <= err_cnt_d;
            if (load) begin
                vec_q <= in_data;
                dir_q <= in_dir;
            end
        end
    end

    assign order_err = order_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_m_sorted_serializer.sv
// Randomised and directed bench for m_sorted_serializer against a queue-based stream model.
module tb_m_sorted_serializer;

    localparam int N = 4;
    localparam int M = 4;

    typedef logic [N-1:0] vec_t [M-1:0];
    typedef struct {int data; int idx; bit last;} elem_t;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    vec_t         in_data;
    logic         in_valid = 1'b0;
    logic         in_dir = 1'b0;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic [1:0]   out_idx;
    logic         out_valid;
    logic         out_last;
    logic         out_ready = 1'b0;
    logic         order_err;
    logic [7:0]   err_cnt;

    m_sorted_serializer #(.N(N), .M(M)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_dir    (in_dir),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .order_err (order_err),
        .err_cnt   (err_cnt)
    );

    always #5 Clk = ~Clk;

    int    checks = 0;
    int    passes = 0;
    elem_t exp_q[$];
    bit    exp_err = 0;
    int    exp_err_cnt = 0;
    int    cyc = 0;
    int    got_data[$];
    int    got_idx[$];
    int    got_cyc[$];
    int    got_err[$];
    bit    rand_rdy = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_unsorted(input vec_t v);
        for (int i = 0; i < M - 1; i++) if (v[i] > v[i+1]) return 1'b1;
        return 1'b0;
    endfunction

    // Model: the state a cycle holds is checked, then the coming edge is applied to it.
    initial begin
        forever begin
            bit exp_rdy;
            vec_t v;
            @(negedge Clk);
            cyc++;
            if (Reset) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 0);
                chk("rst_order_err", order_err, 0);
                chk("rst_err_cnt", err_cnt, 0);
                chk("rst_out_data", out_data, 0);
                exp_q.delete();
                exp_err = 0;
                exp_err_cnt = 0;
            end else begin
                exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
                chk("out_valid", out_valid, exp_q.size() != 0);
                chk("in_ready", in_ready, exp_rdy);
                chk("order_err", order_err, exp_err);
                chk("err_cnt", err_cnt, exp_err_cnt);
                if (exp_q.size() != 0) begin
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_idx", out_idx, exp_q[0].idx);
                    chk("out_last", out_last, exp_q[0].last);
                end
                if (out_valid && out_ready) begin
                    got_data.push_back(out_data);
                    got_idx.push_back(out_idx);
                    got_cyc.push_back(cyc);
                    got_err.push_back(order_err);
                end
                exp_err = 0;
                if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
                if (in_valid && exp_rdy) begin
                    v = in_data;
                    for (int i = 0; i < M; i++) begin
                        elem_t e;
                        e.idx  = in_dir ? M - 1 - i : i;
                        e.data = v[e.idx];
                        e.last = (i == M - 1);
                        exp_q.push_back(e);
                    end
                    if (is_unsorted(v)) begin
                        exp_err = 1;
                        if (exp_err_cnt < 255) exp_err_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input vec_t v, input bit d);
        bit done = 0;
        in_data  = v;
        in_dir   = d;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge Clk);
            if (in_ready) begin
                @(posedge Clk);
                #1;
                done = 1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic send4(input int a, input int b, input int c, input int e, input bit d);
        vec_t v;
        v[0] = N'(a); v[1] = N'(b); v[2] = N'(c); v[3] = N'(e);
        send(v, d);
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(posedge Clk);
            #1;
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic clear_got();
        got_data.delete(); got_idx.delete(); got_cyc.delete(); got_err.delete();
    endtask

    task automatic chk_seq(input string name, input int d0, input int d1, input int d2,
                           input int d3, input int i0, input int i3);
        int ed[4];
        ed = '{d0, d1, d2, d3};
        chk({name, "_count"}, got_data.size(), 4);
        if (got_data.size() == 4) begin
            for (int i = 0; i < 4; i++) chk({name, "_data"}, got_data[i], ed[i]);
            chk({name, "_idx_first"}, got_idx[0], i0);
            chk({name, "_idx_last"}, got_idx[3], i3);
        end
    endtask

    initial begin
        int exp12[12];
        int pat[7];
        exp12 = '{1, 2, 3, 4, 5, 7, 7, 8, 0, 0, 1, 1};
        pat   = '{1, 0, 0, 1, 1, 0, 1};
        in_data = '{default: '0};

        #3;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_err_cnt", err_cnt, 0);
        #4 Reset = 1'b0;
        #1 chk("release_in_ready", in_ready, 1);

        out_ready = 1'b1;
        clear_got();
        send4(1, 2, 6, 8, 0);
        wait_drain();
        chk_seq("asc", 1, 2, 6, 8, 0, 3);

        clear_got();
        send4(1, 2, 6, 8, 1);
        wait_drain();
        chk_seq("desc", 8, 6, 2, 1, 3, 0);

        clear_got();
        send4(1, 2, 3, 4, 0);
        send4(5, 7, 7, 8, 0);
        send4(0, 0, 1, 1, 0);
        wait_drain();
        chk("b2b_count", got_data.size(), 12);
        if (got_data.size() == 12) begin
            for (int i = 0; i < 12; i++) chk("b2b_data", got_data[i], exp12[i]);
            for (int i = 1; i < 12; i++) chk("b2b_no_bubble", got_cyc[i] - got_cyc[i-1], 1);
        end
        chk("b2b_err_cnt", err_cnt, 0);

        clear_got();
        out_ready = 1'b0;
        send4(1, 2, 3, 4, 0);
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i][0];
            @(posedge Clk);
            #1;
        end
        out_ready = 1'b1;
        wait_drain();
        chk_seq("stall", 1, 2, 3, 4, 0, 3);

        clear_got();
        send4(8, 6, 1, 2, 0);
        wait_drain();
        chk_seq("unsorted", 8, 6, 1, 2, 0, 3);
        if (got_err.size() == 4) begin
            chk("unsorted_err_first", got_err[0], 1);
            for (int i = 1; i < 4; i++) chk("unsorted_err_rest", got_err[i], 0);
        end
        chk("unsorted_err_cnt", err_cnt, 1);

        for (int k = 0; k < 300; k++) send4(15, 0, $urandom_range(0, 15), $urandom_range(0, 15), 0);
        wait_drain();
        chk("err_cnt_saturate", err_cnt, 255);

        send4(4, 4, 8, 9, 0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_last", out_last, 0);
        chk("midreset_err_cnt", err_cnt, 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        #1 chk("midreset_release_in_ready", in_ready, 1);
        clear_got();
        send4(0, 1, 2, 3, 0);
        wait_drain();
        chk_seq("after_reset", 0, 1, 2, 3, 0, 3);

        rand_rdy = 1;
        for (int k = 0; k < 150; k++) begin
            vec_t v;
            for (int i = 0; i < M; i++) v[i] = N'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int a = 0; a < M - 1; a++)
                    for (int b = 0; b < M - 1 - a; b++)
                        if (v[b] > v[b+1]) begin
                            logic [N-1:0] t;
                            t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                        end
            end
            send(v, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            #1;
        end
        rand_rdy = 0;
        @(posedge Clk);
        #1 out_ready = 1'b1;
        wait_drain();
        @(negedge Clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
